mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter_pkg.sv | 21 ++
 rtl/mem_bus_arbiter.sv | 59 +++++
 tb/tb_mem_bus_arbiter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared Avalon-MM bus types and port indices
package mem_bus_arbiter_pkg;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;
  typedef struct packed {
    logic [AW-1:0]   address;
    logic [DW-1:0]   writedata;
    logic [DW/8-1:0] byteenable;
    logic            read;
    logic            write;
  } avalon_req_t;
  typedef struct packed {
    logic [DW-1:0] readdata;
    logic          waitrequest;
  } avalon_resp_t;
  function automatic logic is_req(input avalon_req_t r);
    return r.read | r.write;
  endfunction
endpackage

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: 2:1 Avalon-MM arbiter with transfer locking and contention counter
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  avalon_req_t  ibus_avalon_req,
  output avalon_resp_t ibus_avalon_resp,
  input  avalon_req_t  dbus_avalon_req,
  output avalon_resp_t dbus_avalon_resp,
  output avalon_req_t  mem_avalon_req,
  input  avalon_resp_t mem_avalon_resp,
  output logic [31:0]  contention_cnt
);
  typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} state_e;
  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic [31:0] cnt_q, cnt_d;
  logic        i_req, d_req, tie_w, winner, has_win, fire;
  // State, last-served port and contention counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= PORT_D;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end
  // Pick the winner; a lock pins the owner, rst suppresses all forwarding
  always_comb begin
    i_req   = is_req(ibus_avalon_req);
    d_req   = is_req(dbus_avalon_req);
    tie_w   = FIXED_PRIORITY ? PORT_D : ~last_q;
    winner  = state_q == LOCK_I ? PORT_I :
              state_q == LOCK_D ? PORT_D :
              (i_req && d_req)  ? tie_w  :
              d_req             ? PORT_D : PORT_I;
    has_win = !rst && (state_q == LOCK_I ? i_req :
                       state_q == LOCK_D ? d_req : (i_req || d_req));
    fire    = has_win && !mem_avalon_resp.waitrequest;
    state_d = fire ? IDLE : has_win ? (winner == PORT_D ? LOCK_D : LOCK_I) : IDLE;
    last_d  = fire ? winner : last_q;
    cnt_d   = cnt_q + {31'b0, has_win && i_req && d_req};
  end
  // Request mux and response steering
  always_comb begin
    mem_avalon_req = !has_win ? '0 : winner == PORT_D ? dbus_avalon_req : ibus_avalon_req;
    ibus_avalon_resp.readdata    = mem_avalon_resp.readdata;
    dbus_avalon_resp.readdata    = mem_avalon_resp.readdata;
    ibus_avalon_resp.waitrequest = (has_win && winner == PORT_I) ? mem_avalon_resp.waitrequest : 1'b1;
    dbus_avalon_resp.waitrequest = (has_win && winner == PORT_D) ? mem_avalon_resp.waitrequest : 1'b1;
  end
  assign contention_cnt = cnt_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: scoreboard bench for the round-robin and fixed-priority arbiter
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;
  typedef struct {
    logic        port;
    logic [31:0] addr;
  } exp_t;
  logic         clk = 0;
  logic         rst = 1;
  avalon_req_t  ibus_req, dbus_req, mem_req, mem_req_fp;
  avalon_resp_t ibus_resp, dbus_resp, mem_resp, ibus_resp_fp, dbus_resp_fp;
  logic [31:0]  cnt, cnt_fp;
  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  always #5 clk = ~clk;
  mem_bus_arbiter #(.FIXED_PRIORITY(1'b0)) dut (
    .clk(clk), .rst(rst),
    .ibus_avalon_req(ibus_req), .ibus_avalon_resp(ibus_resp),
    .dbus_avalon_req(dbus_req), .dbus_avalon_resp(dbus_resp),
    .mem_avalon_req(mem_req), .mem_avalon_resp(mem_resp),
    .contention_cnt(cnt)
  );
  mem_bus_arbiter #(.FIXED_PRIORITY(1'b1)) dut_fp (
    .clk(clk), .rst(rst),
    .ibus_avalon_req(ibus_req), .ibus_avalon_resp(ibus_resp_fp),
    .dbus_avalon_req(dbus_req), .dbus_avalon_resp(dbus_resp_fp),
    .mem_avalon_req(mem_req_fp), .mem_avalon_resp(mem_resp),
    .contention_cnt(cnt_fp)
  );
  function automatic avalon_req_t mk(input logic [31:0] a, input logic rd, input logic wr);
    avalon_req_t r;
    r = '0;
    r.address = a;
    r.writedata = a ^ 32'h5A5A_0000;
    r.byteenable = 4'hF;
    r.read = rd;
    r.write = wr;
    return r;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic expect_grant(input logic p, input logic [31:0] a);
    exp_t e;
    e.port = p;
    e.addr = a;
    sb.push_back(e);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1;
    step();
    rst = 0;
  endtask
  // Monitor: every fired slave transfer must match the oldest expected grant
  always @(negedge clk) begin
    if (!rst && (mem_req.read || mem_req.write) && !mem_resp.waitrequest) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_grant: addr 0x%08h with nothing expected at %0t", mem_req.address, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("grant_port", {31'b0, ibus_resp.waitrequest}, {31'b0, e.port});
        chk("grant_addr", mem_req.address, e.addr);
      end
    end
  end
  initial begin
    ibus_req = '0;
    dbus_req = '0;
    mem_resp = '0;
    rst = 1;
    ibus_req = mk(32'h10, 1, 0);
    dbus_req = mk(32'h20, 0, 1);
    @(negedge clk);
    chk("rst_mem_read", {31'b0, mem_req.read}, 0);
    chk("rst_mem_write", {31'b0, mem_req.write}, 0);
    chk("rst_i_wait", {31'b0, ibus_resp.waitrequest}, 1);
    chk("rst_d_wait", {31'b0, dbus_resp.waitrequest}, 1);
    chk("rst_cnt", cnt, 0);
    ibus_req = '0;
    dbus_req = '0;
    step();
    rst = 0;
    ibus_req = mk(32'h100, 1, 0);
    expect_grant(PORT_I, 32'h100);
    @(negedge clk);
    chk("ird_addr", mem_req.address, 32'h100);
    chk("ird_i_wait", {31'b0, ibus_resp.waitrequest}, 0);
    chk("ird_d_wait", {31'b0, dbus_resp.waitrequest}, 1);
    step();
    ibus_req = '0;
    mem_resp.readdata = 32'hDEAD_BEEF;
    dbus_req = mk(32'h180, 1, 0);
    expect_grant(PORT_D, 32'h180);
    @(negedge clk);
    chk("ird_rdata", ibus_resp.readdata, 32'hDEAD_BEEF);
    chk("idle_d_wait", {31'b0, dbus_resp.waitrequest}, 0);
    step();
    dbus_req = '0;
    do_reset();
    ibus_req = mk(32'h10, 1, 0);
    dbus_req = mk(32'h20, 1, 0);
    for (int k = 0; k < 4; k++) begin
      expect_grant(k[0] ? PORT_D : PORT_I, k[0] ? 32'h20 : 32'h10);
      @(negedge clk);
      chk("rr_mem_addr", mem_req.address, k[0] ? 32'h20 : 32'h10);
      step();
    end
    ibus_req = '0;
    dbus_req = '0;
    @(negedge clk);
    chk("rr_cnt", cnt, 4);
    step();
    do_reset();
    ibus_req = mk(32'h30, 1, 0);
    dbus_req = mk(32'h40, 0, 1);
    for (int k = 0; k < 3; k++) begin
      expect_grant(k[0] ? PORT_D : PORT_I, k[0] ? 32'h40 : 32'h30);
      @(negedge clk);
      chk("fp_mem_addr", mem_req_fp.address, 32'h40);
      chk("fp_i_wait", {31'b0, ibus_resp_fp.waitrequest}, 1);
      chk("fp_d_wait", {31'b0, dbus_resp_fp.waitrequest}, 0);
      step();
    end
    ibus_req = '0;
    dbus_req = '0;
    @(negedge clk);
    chk("fp_cnt", cnt_fp, 3);
    step();
    do_reset();
    dbus_req = mk(32'h2000, 0, 1);
    mem_resp.waitrequest = 1;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) ibus_req = mk(32'h300, 1, 0);
      @(negedge clk);
      chk("lockd_addr", mem_req.address, 32'h2000);
      chk("lockd_write", {31'b0, mem_req.write}, 1);
      chk("lockd_i_wait", {31'b0, ibus_resp.waitrequest}, 1);
      step();
    end
    mem_resp.waitrequest = 0;
    expect_grant(PORT_D, 32'h2000);
    @(negedge clk);
    chk("lockd_fire_i_wait", {31'b0, ibus_resp.waitrequest}, 1);
    step();
    dbus_req = '0;
    expect_grant(PORT_I, 32'h300);
    @(negedge clk);
    chk("lockd_then_i", {31'b0, ibus_resp.waitrequest}, 0);
    chk("lockd_cnt", cnt, 2);
    step();
    ibus_req = '0;
    do_reset();
    ibus_req = mk(32'h400, 1, 0);
    dbus_req = mk(32'h500, 1, 0);
    mem_resp.waitrequest = 1;
    step();
    @(negedge clk);
    chk("locki_addr", mem_req.address, 32'h400);
    chk("locki_d_wait", {31'b0, dbus_resp.waitrequest}, 1);
    chk("locki_cnt", cnt, 1);
    step();
    rst = 1;
    @(negedge clk);
    chk("rst_lock_read", {31'b0, mem_req.read}, 0);
    chk("rst_lock_i_wait", {31'b0, ibus_resp.waitrequest}, 1);
    step();
    rst = 0;
    ibus_req = '0;
    mem_resp.waitrequest = 0;
    expect_grant(PORT_D, 32'h500);
    @(negedge clk);
    chk("post_rst_cnt", cnt, 0);
    chk("post_rst_d_wait", {31'b0, dbus_resp.waitrequest}, 0);
    step();
    dbus_req = '0;
    do_reset();
    ibus_req = mk(32'h600, 1, 0);
    dbus_req = mk(32'h700, 0, 1);
    mem_resp.waitrequest = 1;
    step();
    ibus_req = '0;
    @(negedge clk);
    chk("abort_read", {31'b0, mem_req.read}, 0);
    chk("abort_write", {31'b0, mem_req.write}, 0);
    chk("abort_d_wait", {31'b0, dbus_resp.waitrequest}, 1);
    step();
    mem_resp.waitrequest = 0;
    expect_grant(PORT_D, 32'h700);
    @(negedge clk);
    chk("abort_d_grant", {31'b0, dbus_resp.waitrequest}, 0);
    step();
    do_reset();
    ibus_req = mk(32'h600, 1, 0);
    dbus_req = mk(32'h700, 0, 1);
    mem_resp.waitrequest = 1;
    step();
    ibus_req = '0;
    step();
    ibus_req = mk(32'h600, 1, 0);
    mem_resp.waitrequest = 0;
    expect_grant(PORT_I, 32'h600);
    step();
    expect_grant(PORT_D, 32'h700);
    step();
    ibus_req = '0;
    dbus_req = '0;
    step();
    step();
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
